instr_encode_loader: RTL and testbench
======================================

// Module: instr_encode_loader
// PURPOSE
//  Inverse of the single-cycle control decoder: accepts instruction descriptors (class + fields)
//  over a valid/ready handshake, encodes each into a 32-bit MIPS word (R/LW/SW/BEQ/BNE/J/ADDI),
//  writes it to instruction memory at consecutive word addresses. Sits between a bench/host
//  program source and the imem write port; loads programs for the single-cycle core.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of first written word
//  DEPTH      64             max words per load; power of 2, >=2
//  ADDR_W     32             width of imem_addr
// PORTS
//  clk         in   1       rising-edge clock
//  reset_n     in   1       asynchronous, active-low reset
//  start       in   1       begin new load (sampled in IDLE/DONE only)
//  in_valid    in   1       descriptor valid
//  in_ready    out  1       loader can accept descriptor this cycle
//  op_sel      in   3       0=R_FORMAT 1=LW 2=SW 3=BEQ 4=BNE 5=J 6=ADDI 7=illegal
//  rs,rt,rd    in   5 each  register fields
//  funct       in   6       R-type funct
//  imm         in   16      I-type immediate / branch offset
//  target      in   26      J-type target
//  last        in   1       descriptor is final word of program
//  imem_we     out  1       imem write strobe
//  imem_addr   out  ADDR_W  byte address, word aligned
//  imem_wdata  out  32      encoded instruction
//  count       out  $clog2(DEPTH)+1  words written this load
//  done        out  1       load complete (level)
//  err         out  1       sticky: illegal op_sel or overflow
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; in_ready=0, imem_we=0, imem_addr=BASE_ADDR,
//    imem_wdata=0, count=0, done=0, err=0.
//  - FSM IDLE -> LOAD on start; DONE -> LOAD on start. LOAD -> DONE when accepted word has
//    last=1 or count reaches DEPTH. start in LOAD ignored.
//  - Entering LOAD: next address=BASE_ADDR, count=0, done=0, err=0.
//  - in_ready = (state==LOAD) && (count + pending < DEPTH). Accept when in_valid&&in_ready.
//  - Latency 1: descriptor accepted in cycle N -> imem_we=1 with imem_wdata/imem_addr in N+1.
//    Back-to-back accepts give one write per cycle; no bubbles.
//  - Address increments by 4 after each write; count increments with each imem_we.
//  - Encoding: R {6'd0,rs,rt,rd,5'd0,funct}; LW {6'd35,rs,rt,imm}; SW {6'd43,rs,rt,imm};
//    BEQ {6'd4,rs,rt,imm}; BNE {6'd5,rs,rt,imm}; ADDI {6'd8,rs,rt,imm}; J {6'd2,target}.
//  - op_sel=7: descriptor consumed, no write, count unchanged, err set; if last=1 still -> DONE.
//  - Overflow: accept with in_valid=1 not possible once DEPTH reached; FSM -> DONE, err=1
//    if last was not seen on final word.
//  - done=1 in DONE only, the cycle after final write; held until next start.
//  - imem_addr wraps modulo 2^ADDR_W (no special handling).
//  - reset_n low mid-load: immediate abort, all outputs to reset values, no partial strobe.
// STRUCTURE
//  - Shared package/include mips_defs: opcode constants (R_FORMAT, LW, SW, BEQ, BNE, J, ADDI)
//    shared with control decoder; op_sel encodings; FSM state encodings.
//  - One combinational sub-module instr_pack (op_sel+fields -> 32-bit word, illegal flag);
//    top holds FSM, output register, address/count counters.
// TESTING
//  - R add: op_sel=0 rs=1 rt=2 rd=3 funct=0x20 -> cycle+1 imem_we=1 addr=BASE wdata=0x00221820
//  - Burst of 5 back-to-back: LW rs=1 rt=2 imm=4 ->0x8C220004; SW imm=8 ->0xAC220008;
//    BEQ imm=0xFFFF ->0x1022FFFF; ADDI rs=0 rt=1 imm=5 ->0x20010005; J target=0x10 last=1
//    ->0x08000010; addrs BASE..BASE+16, count=5, done=1 next cycle
//  - Illegal op_sel=7 mid-stream -> no write, address not advanced, err=1 sticky, count unchanged
//  - DEPTH=4, six descriptors no last -> four writes, in_ready=0 after 4th accept, DONE, err=1
//  - reset_n low during burst -> same cycle imem_we=0, count=0, state IDLE; restart reloads BASE
//  - in_valid gaps/toggling and start asserted in LOAD -> no duplicate/missed writes, start ignored

Source files
------------

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS opcode, op_sel and loader state encodings
package mips_defs;

  // Primary opcode field values, shared with the control decoder
  localparam logic [5:0] OPC_R_FORMAT = 6'd0;
  localparam logic [5:0] OPC_LW       = 6'd35;
  localparam logic [5:0] OPC_SW       = 6'd43;
  localparam logic [5:0] OPC_BEQ      = 6'd4;
  localparam logic [5:0] OPC_BNE      = 6'd5;
  localparam logic [5:0] OPC_J        = 6'd2;
  localparam logic [5:0] OPC_ADDI     = 6'd8;

  // Descriptor class as presented on op_sel
  typedef enum logic [2:0] {
    OP_R_FORMAT = 3'd0,
    OP_LW       = 3'd1,
    OP_SW       = 3'd2,
    OP_BEQ      = 3'd3,
    OP_BNE      = 3'd4,
    OP_J        = 3'd5,
    OP_ADDI     = 3'd6,
    OP_ILLEGAL  = 3'd7
  } op_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational descriptor to 32-bit MIPS word encoder
module instr_pack
  import mips_defs::*;
(
  input  logic [2:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Assemble the instruction fields for the selected class; unknown class flags illegal
  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (op_sel_e'(op_sel))
      OP_R_FORMAT: word = {OPC_R_FORMAT, rs, rt, rd, 5'd0, funct};
      OP_LW:       word = {OPC_LW, rs, rt, imm};
      OP_SW:       word = {OPC_SW, rs, rt, imm};
      OP_BEQ:      word = {OPC_BEQ, rs, rt, imm};
      OP_BNE:      word = {OPC_BNE, rs, rt, imm};
      OP_J:        word = {OPC_J, target};
      OP_ADDI:     word = {OPC_ADDI, rs, rt, imm};
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - encodes instruction descriptors and writes them to imem
module instr_encode_loader
  import mips_defs::*;
#(
  parameter int unsigned        DEPTH     = 64,
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op_sel,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [5:0]               funct,
  input  logic [15:0]              imm,
  input  logic [25:0]              target,
  input  logic                     last,
  output logic                     imem_we,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic [31:0]              imem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  state_e            state_q, state_d;
  logic              fin_q, fin_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CW-1:0]     count_q, count_d;

  logic [31:0]       word;
  logic              illegal;
  logic [CW:0]       total;
  logic              accept;
  logic              fills;

  instr_pack u_pack (
    .op_sel  (op_sel),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .funct   (funct),
    .imm     (imm),
    .target  (target),
    .word    (word),
    .illegal (illegal)
  );

  // Words written plus the one in flight; fin_q blocks accepts once the program end is booked
  assign total    = {1'b0, count_q} + {{CW{1'b0}}, we_q};
  assign in_ready = (state_q == ST_LOAD) && !fin_q && (total < DEPTH_L);
  assign accept   = in_valid && in_ready;
  assign fills    = !illegal && ((total + (CW+1)'(1)) == DEPTH_L);

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

  // Next-state: FSM, write register, address/count advance after each write
  always_comb begin
    state_d = state_q;
    fin_d   = fin_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;

    if (we_q) begin
      addr_d  = addr_q + ADDR_W'(4);
      count_d = count_q + CW'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          fin_d   = 1'b0;
          err_d   = 1'b0;
          addr_d  = BASE_ADDR;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (fin_q) begin
          state_d = ST_DONE;
        end else if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            wdata_d = word;
          end
          if (last || fills) fin_d = 1'b1;
          if (fills && !last) err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared immediately on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb/tb_instr_encode_loader.sv - scoreboard bench for instr_encode_loader
module tb_instr_encode_loader;

  localparam logic [31:0] BASE_A = 32'h0000_0100;
  localparam logic [31:0] BASE_B = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_a, start_b;
  logic        in_valid;
  logic [2:0]  op_sel;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        last;

  logic        in_ready_a, we_a, done_a, err_a;
  logic [31:0] addr_a, wdata_a;
  logic [6:0]  count_a;
  logic        in_ready_b, we_b, done_b, err_b;
  logic [31:0] addr_b, wdata_b;
  logic [2:0]  count_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit sel = 1'b0;
  logic [31:0] ea, eb;
  logic [63:0] qa[$];
  logic [63:0] qb[$];

  always #5 clk = ~clk;

  instr_encode_loader #(.DEPTH(64), .ADDR_W(32), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
    .last(last), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a), .count(count_a),
    .done(done_a), .err(err_a)
  );

  instr_encode_loader #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
    .last(last), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b), .count(count_b),
    .done(done_b), .err(err_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops the oldest expected {addr,data}
  always @(negedge clk) begin
    if (reset_n) begin
      if (we_a) begin
        n_checks++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL write_a unexpected actual=%h:%h required=none", addr_a, wdata_a);
        end else begin
          logic [63:0] e;
          e = qa.pop_front();
          if ({addr_a, wdata_a} !== e) begin
            n_fail++;
            $display("FAIL write_a actual=%h:%h required=%h:%h", addr_a, wdata_a, e[63:32], e[31:0]);
          end
        end
      end
      if (we_b) begin
        n_checks++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL write_b unexpected actual=%h:%h required=none", addr_b, wdata_b);
        end else begin
          logic [63:0] e;
          e = qb.pop_front();
          if ({addr_b, wdata_b} !== e) begin
            n_fail++;
            $display("FAIL write_b actual=%h:%h required=%h:%h", addr_b, wdata_b, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge with in_valid still high
  task automatic send(input logic [2:0] op, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                      input logic [25:0] tg, input logic lst, input logic [31:0] word,
                      input bit wr);
    int waited = 0;
    op_sel = op; rs = s; rt = t; rd = d; funct = f; imm = i; target = tg; last = lst;
    in_valid = 1'b1;
    if (wr) begin
      if (sel) begin qb.push_back({eb, word}); eb += 32'd4; end
      else     begin qa.push_back({ea, word}); ea += 32'd4; end
    end
    while (!(sel ? in_ready_b : in_ready_a) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  task automatic go_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    ea  = BASE_A;
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    op_sel = 3'd0; rs = '0; rt = '0; rd = '0; funct = '0; imm = '0; target = '0;
    idle();
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready_a, 0);
    check("rst_we", we_a, 0);
    check("rst_addr", addr_a, BASE_A);
    check("rst_wdata", wdata_a, 0);
    check("rst_count", count_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single R-type add
    go_a();
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b1, 32'h0022_1820, 1);
    idle();
    check("r_done_during_write", done_a, 0);
    @(negedge clk);
    check("r_done", done_a, 1);
    check("r_count", count_a, 1);
    check("r_err", err_a, 0);

    // Back-to-back burst of five
    go_a();
    send(3'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0, 32'h8C22_0004, 1);
    send(3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0008, 26'h0, 1'b0, 32'hAC22_0008, 1);
    send(3'd3, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b0, 32'h1022_FFFF, 1);
    send(3'd6, 5'd0, 5'd1, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b0, 32'h2001_0005, 1);
    send(3'd5, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1, 32'h0800_0010, 1);
    idle();
    check("burst_done_during_write", done_a, 0);
    check("burst_ready_after_last", in_ready_a, 0);
    @(negedge clk);
    check("burst_done", done_a, 1);
    check("burst_count", count_a, 5);
    check("burst_err", err_a, 0);

    // Illegal descriptor mid-stream
    go_a();
    check("restart_err_clear", err_a, 0);
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0, 32'h0022_1820, 1);
    send(3'd7, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0, 32'h0, 0);
    check("ill_err", err_a, 1);
    check("ill_count", count_a, 1);
    check("ill_we", we_a, 0);
    send(3'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b1, 32'h8C22_0004, 1);
    idle();
    @(negedge clk);
    check("ill_done", done_a, 1);
    check("ill_err_sticky", err_a, 1);
    check("ill_final_count", count_a, 2);

    // Gaps in in_valid and start pulsed while loading
    go_a();
    send(3'd4, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0010, 26'h0, 1'b0, 32'h1422_0010, 1);
    idle();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("gap_start_ignored_count", count_a, 1);
    send(3'd1, 5'd29, 5'd8, 5'd0, 6'h0, 16'h0020, 26'h0, 1'b0, 32'h8FA8_0020, 1);
    idle();
    @(negedge clk);
    send(3'd6, 5'd0, 5'd1, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b1, 32'h2001_0005, 1);
    idle();
    @(negedge clk);
    check("gap_done", done_a, 1);
    check("gap_count", count_a, 3);

    // Overflow on the DEPTH=4 instance
    sel = 1'b1;
    eb  = BASE_B;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 4; k++)
      send(3'd6, 5'd0, 5'd1, 5'd0, 6'h0, 16'(k + 1), 26'h0, 1'b0, {16'h2001, 16'(k + 1)}, 1);
    check("ovf_ready_after_4", in_ready_b, 0);
    imm = 16'h0005;
    @(negedge clk);
    imm = 16'h0006;
    @(negedge clk);
    @(negedge clk);
    idle();
    check("ovf_done", done_b, 1);
    check("ovf_err", err_b, 1);
    check("ovf_count", count_b, 4);
    check("ovf_a_untouched", done_a, 1);

    // Reset in the middle of a burst
    go_a();
    send(3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0008, 26'h0, 1'b0, 32'hAC22_0008, 1);
    send(3'd3, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b0, 32'h1022_FFFF, 1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_we", we_a, 0);
    check("abort_count", count_a, 0);
    check("abort_ready", in_ready_a, 0);
    check("abort_addr", addr_a, BASE_A);
    check("abort_done", done_a, 0);
    idle();
    qa.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    go_a();
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b1, 32'h0022_1820, 1);
    idle();
    @(negedge clk);
    check("reload_done", done_a, 1);
    check("reload_count", count_a, 1);

    repeat (2) @(negedge clk);
    check("queue_a_drained", qa.size(), 0);
    check("queue_b_drained", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
